enum_seq_fsm: RTL and testbench

ENUM_SEQ_FSM -- requirements
Module: enum_seq_fsm

---
 rtl/enum_seq_pkg.sv | 14 +
 rtl/dwell_cnt.sv | 41 ++++
 rtl/enum_seq_fsm.sv | 109 ++++++++++
 tb/tb_enum_seq_fsm.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/enum_seq_pkg.sv
// Shared types for the enumerated state sequencer: wrap direction and sequencing mode.
package enum_seq_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP   = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

endpackage

// File: rtl/dwell_cnt.sv
// Per-state dwell counter: done is raised on the enabled cycle where cnt has reached dwell.
// Latency: done is combinational from the registered count; en low stalls, clr wins over en.
module dwell_cnt #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               done
);

    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_d;

    // dwell is compared live, so a lowered dwell below cnt fires on the next enabled cycle
    always_comb begin
        cnt_d = cnt_q;
        done  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q >= dwell) begin
                done  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + DWELL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/enum_seq_fsm.sv
// Index sequencer stepping through NUM_STATES states in wrap or bounce order with a per-state dwell.
// Latency: outputs registered, pulses coincide with the new index; en low freezes everything.
module enum_seq_fsm
    import enum_seq_pkg::*;
#(
    parameter int NUM_STATES = 3,
    parameter int DWELL_W    = 4,
    parameter int STATE_W    = $clog2(NUM_STATES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               sync_clr,
    input  logic               dir,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
    output logic [STATE_W-1:0] state_idx,
    output logic               state_chg,
    output logic               turn
);

    localparam logic [STATE_W-1:0] LAST = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] ONE  = STATE_W'(1);

    logic [STATE_W-1:0] state_q, state_d;
    dir_e               bdir_q, bdir_d;
    logic               chg_q, chg_d;
    logic               turn_q, turn_d;
    logic               adv;

    dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (sync_clr),
        .dwell (dwell),
        .done  (adv)
    );

    always_comb begin
        state_d = state_q;
        bdir_d  = bdir_q;
        chg_d   = 1'b0;
        turn_d  = 1'b0;
        if (sync_clr) begin
            state_d = '0;
            bdir_d  = DIR_UP;
        end else if (adv) begin
            chg_d = 1'b1;
            if (mode_e'(mode) == MODE_WRAP) begin
                if (dir_e'(dir) == DIR_UP) begin
                    if (state_q == LAST) begin
                        state_d = '0;
                        turn_d  = 1'b1;
                    end else begin
                        state_d = state_q + ONE;
                    end
                end else begin
                    if (state_q == '0) begin
                        state_d = LAST;
                        turn_d  = 1'b1;
                    end else begin
                        state_d = state_q - ONE;
                    end
                end
            end else begin
                // Bounce reflects off either end; bdir only moves here so it survives wrap-mode spells
                if (bdir_q == DIR_UP) begin
                    if (state_q == LAST) begin
                        state_d = state_q - ONE;
                        bdir_d  = DIR_DOWN;
                        turn_d  = 1'b1;
                    end else begin
                        state_d = state_q + ONE;
                    end
                end else begin
                    if (state_q == '0) begin
                        state_d = ONE;
                        bdir_d  = DIR_UP;
                        turn_d  = 1'b1;
                    end else begin
                        state_d = state_q - ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            bdir_q  <= DIR_UP;
            chg_q   <= 1'b0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bdir_q  <= bdir_d;
            chg_q   <= chg_d;
            turn_q  <= turn_d;
        end
    end

    assign state_idx = state_q;
    assign state_chg = chg_q;
    assign turn      = turn_q;

endmodule

// File: tb/tb_enum_seq_fsm.sv
// Random and directed bench for enum_seq_fsm at N=3,4,2,5 against a position/direction reference model.
module tb_enum_seq_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       sync_clr = 1'b0;
    logic       dir = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] dwell = 4'd0;

    logic [1:0] idx3, idx4;
    logic [0:0] idx2;
    logic [2:0] idx5;
    logic       chg3, chg4, chg2, chg5;
    logic       turn3, turn4, turn2, turn5;

    always #5 clk = ~clk;

    enum_seq_fsm #(.NUM_STATES(3), .DWELL_W(4)) u_n3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .dir(dir), .mode(mode),
        .dwell(dwell), .state_idx(idx3), .state_chg(chg3), .turn(turn3));
    enum_seq_fsm #(.NUM_STATES(4), .DWELL_W(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .dir(dir), .mode(mode),
        .dwell(dwell), .state_idx(idx4), .state_chg(chg4), .turn(turn4));
    enum_seq_fsm #(.NUM_STATES(2), .DWELL_W(4)) u_n2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .dir(dir), .mode(mode),
        .dwell(dwell), .state_idx(idx2), .state_chg(chg2), .turn(turn2));
    enum_seq_fsm #(.NUM_STATES(5), .DWELL_W(4)) u_n5 (
        .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr), .dir(dir), .mode(mode),
        .dwell(dwell), .state_idx(idx5), .state_chg(chg5), .turn(turn5));

    int n_checks = 0;
    int n_errors = 0;

    int nn[4] = '{3, 4, 2, 5};
    int m_idx[4];
    int m_cnt[4];
    int m_down[4];
    int m_chg[4];
    int m_turn[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_idx[k]  = 0;
            m_cnt[k]  = 0;
            m_down[k] = 0;
            m_chg[k]  = 0;
            m_turn[k] = 0;
        end
    endfunction

    function automatic void model_step();
        int nxt;
        for (int k = 0; k < 4; k++) begin
            m_chg[k]  = 0;
            m_turn[k] = 0;
            if (sync_clr) begin
                m_idx[k]  = 0;
                m_cnt[k]  = 0;
                m_down[k] = 0;
            end else if (en) begin
                if (m_cnt[k] >= int'(dwell)) begin
                    m_cnt[k] = 0;
                    m_chg[k] = 1;
                    if (mode == 1'b0) begin
                        if (dir == 1'b0) begin
                            m_turn[k] = (m_idx[k] == nn[k] - 1) ? 1 : 0;
                            m_idx[k]  = (m_idx[k] + 1) % nn[k];
                        end else begin
                            m_turn[k] = (m_idx[k] == 0) ? 1 : 0;
                            m_idx[k]  = (m_idx[k] + nn[k] - 1) % nn[k];
                        end
                    end else begin
                        nxt = m_idx[k] + (m_down[k] != 0 ? -1 : 1);
                        if (nxt < 0 || nxt >= nn[k]) begin
                            m_down[k] = (m_down[k] != 0) ? 0 : 1;
                            nxt = m_idx[k] + (m_down[k] != 0 ? -1 : 1);
                            m_turn[k] = 1;
                        end
                        m_idx[k] = nxt;
                    end
                end else begin
                    m_cnt[k]++;
                end
            end
        end
    endfunction

    task automatic check_all();
        chk("n3_idx", 32'(idx3), m_idx[0]);  chk("n3_chg", 32'(chg3), m_chg[0]);  chk("n3_turn", 32'(turn3), m_turn[0]);
        chk("n4_idx", 32'(idx4), m_idx[1]);  chk("n4_chg", 32'(chg4), m_chg[1]);  chk("n4_turn", 32'(turn4), m_turn[1]);
        chk("n2_idx", 32'(idx2), m_idx[2]);  chk("n2_chg", 32'(chg2), m_chg[2]);  chk("n2_turn", 32'(turn2), m_turn[2]);
        chk("n5_idx", 32'(idx5), m_idx[3]);  chk("n5_chg", 32'(chg5), m_chg[3]);  chk("n5_turn", 32'(turn5), m_turn[3]);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point
    task automatic step(input logic e, input logic sc, input logic d, input logic m, input logic [3:0] dw);
        en = e; sync_clr = sc; dir = d; mode = m; dwell = dw;
        @(posedge clk);
        #1;
        model_step();
        check_all();
    endtask

    int exp31_idx[5]  = '{1, 2, 0, 1, 2};
    int exp31_turn[5] = '{0, 0, 1, 0, 0};
    int exp32_idx[9]  = '{0, 0, 2, 2, 2, 1, 1, 1, 0};
    int exp32_chg[9]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    int exp33_idx[7]  = '{1, 2, 3, 2, 1, 0, 1};
    int exp33_turn[7] = '{0, 0, 0, 1, 0, 0, 1};
    int exp33_n2[3]   = '{1, 0, 1};

    logic       r_dir, r_mode, r_en, r_clr;
    logic [3:0] r_dw;

    initial begin
        model_reset();
        #1;
        check_all();
        #20;
        rst_n = 1'b1;

        // wrap up, dwell 0
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            chk("wrap_up_idx", 32'(idx3), exp31_idx[i]);
            chk("wrap_up_turn", 32'(turn3), exp31_turn[i]);
        end

        // wrap down, dwell 2
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd2);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
            chk("wrap_dn_idx", 32'(idx3), exp32_idx[i]);
            chk("wrap_dn_chg", 32'(chg3), exp32_chg[i]);
        end

        // bounce, dwell 0
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
            chk("bounce4_idx", 32'(idx4), exp33_idx[i]);
            chk("bounce4_turn", 32'(turn4), exp33_turn[i]);
            if (i < 3) chk("bounce2_idx", 32'(idx2), exp33_n2[i]);
        end

        // enable gap mid-dwell
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 4'd3);

        // sync clear overrides enable
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("pre_clr_idx", 32'(idx3), 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("clr_idx", 32'(idx3), 0);
        chk("clr_chg", 32'(chg3), 0);
        chk("clr_turn", 32'(turn3), 0);

        // asynchronous reset between edges, mid-dwell
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        r_dir = 1'b0; r_mode = 1'b0; r_dw = 4'd1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) r_dir = ~r_dir;
            if ($urandom_range(0, 19) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 9) == 0)
                r_dw = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            r_en  = ($urandom_range(0, 3) != 0);
            r_clr = ($urandom_range(0, 49) == 0);
            step(r_en, r_clr, r_dir, r_mode, r_dw);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
